// File: rtl/ucounter_arb_if.sv
// ucounter_arb_if -- signal bundle between the shared-counter arbiter, its two
// requesters and the external loadable up/down counter.
//
//   Requester side : req0/req1, preset0/preset1, up0/up1 (to arbiter)
//                    gnt0/gnt1, done0/done1, abort0/abort1 (from arbiter)
//   Counter side   : _load, preld_val, _updown, _wrapstop, cnt_en (from arbiter)
//                    overflow, dcount (to arbiter)
//   Observation    : count (registered copy of dcount, from arbiter)
//
// Modport slave is the arbiter; modport master is everything around it.
interface ucounter_arb_if;
  logic        req0;
  logic        req1;
  logic [15:0] preset0;
  logic [15:0] preset1;
  logic        up0;
  logic        up1;

  logic        gnt0;
  logic        gnt1;
  logic        done0;
  logic        done1;
  logic        abort0;
  logic        abort1;

  logic        _load;
  logic [15:0] preld_val;
  logic        _updown;
  logic        _wrapstop;
  logic        cnt_en;

  logic        overflow;
  logic [15:0] dcount;
  logic [15:0] count;

  modport slave (
    input  req0, req1, preset0, preset1, up0, up1, overflow, dcount,
    output gnt0, gnt1, done0, done1, abort0, abort1,
           _load, preld_val, _updown, _wrapstop, cnt_en, count
  );

  modport master (
    output req0, req1, preset0, preset1, up0, up1, overflow, dcount,
    input  gnt0, gnt1, done0, done1, abort0, abort1,
           _load, preld_val, _updown, _wrapstop, cnt_en, count
  );
endinterface

// File: rtl/ucounter_arb.sv
// ucounter_arb -- round-robin arbiter giving two requesters exclusive use of
// one external loadable up/down counter.
//
// Ports:
//   clk      : single clock, rising edge
//   _areset  : asynchronous active-low reset
//   bus      : ucounter_arb_if.slave
//     req0/1, preset0/1, up0/1 : job requests, preload values and directions
//     gnt0/1                   : counter currently owned by that requester
//     done0/1                  : one-cycle pulse, owner's job hit terminal count
//     abort0/1                 : one-cycle pulse, owner dropped req early
//     _load, preld_val         : active-low load strobe and preload value
//     _updown, _wrapstop       : counter direction (1=up), terminal mode (0=stop)
//     cnt_en                   : counter clock enable
//     overflow, dcount         : counter terminal flag and value
//     count                    : dcount registered while a grant is held
//
// Job sequence: IDLE (arbitrate, latch preset/up) -> LOAD (one _load pulse)
// -> RUN (count until overflow or owner drops req) -> DONE (done pulse) -> IDLE.
module ucounter_arb (
  input  logic          clk,
  input  logic          _areset,
  ucounter_arb_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic        owner;
  logic        owner_nxt;
  logic        ptr;           // last requester served; 1 after reset so req0 wins first
  logic        ptr_nxt;
  logic [15:0] lat_preset;
  logic [15:0] lat_preset_nxt;
  logic        lat_up;
  logic        lat_up_nxt;
  logic        abort0_q;
  logic        abort1_q;
  logic        abort0_nxt;
  logic        abort1_nxt;
  logic [15:0] count_q;

  logic        busy;
  logic        owner_req;
  logic        winner;

  assign busy      = (state != IDLE);
  assign owner_req = owner ? bus.req1 : bus.req0;

  // With both requesting, the one not served last wins; otherwise the
  // single requester wins (req1 low implies req0 is the requester).
  always_comb begin
    winner = bus.req1;
    if (bus.req0 && bus.req1) begin
      winner = ~ptr;
    end
  end

  always_comb begin
    state_nxt      = state;
    owner_nxt      = owner;
    ptr_nxt        = ptr;
    lat_preset_nxt = lat_preset;
    lat_up_nxt     = lat_up;
    abort0_nxt     = 1'b0;
    abort1_nxt     = 1'b0;

    case (state)
      IDLE: begin
        if (bus.req0 || bus.req1) begin
          state_nxt      = LOAD;
          owner_nxt      = winner;
          lat_preset_nxt = winner ? bus.preset1 : bus.preset0;
          lat_up_nxt     = winner ? bus.up1 : bus.up0;
        end
      end
      LOAD: begin
        // overflow still reflects the previous job here and is ignored
        state_nxt = RUN;
      end
      RUN: begin
        // terminal count takes priority over a simultaneous req drop
        if (bus.overflow) begin
          state_nxt = DONE;
        end else if (!owner_req) begin
          state_nxt  = IDLE;
          ptr_nxt    = owner;
          abort0_nxt = ~owner;
          abort1_nxt = owner;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        ptr_nxt   = owner;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      ptr        <= 1'b1;
      lat_preset <= '0;
      lat_up     <= 1'b1;
      abort0_q   <= 1'b0;
      abort1_q   <= 1'b0;
    end else begin
      state      <= state_nxt;
      owner      <= owner_nxt;
      ptr        <= ptr_nxt;
      lat_preset <= lat_preset_nxt;
      lat_up     <= lat_up_nxt;
      abort0_q   <= abort0_nxt;
      abort1_q   <= abort1_nxt;
    end
  end

  always_ff @(posedge clk or negedge _areset) begin
    if (!_areset) begin
      count_q <= '0;
    end else if (busy) begin
      count_q <= bus.dcount;
    end
  end

  // Outputs are decoded from registered state so reset forces them at once.
  assign bus.gnt0      = busy & ~owner;
  assign bus.gnt1      = busy & owner;
  assign bus.done0     = (state == DONE) & ~owner;
  assign bus.done1     = (state == DONE) & owner;
  assign bus.abort0    = abort0_q;
  assign bus.abort1    = abort1_q;
  assign bus._load     = (state != LOAD);
  assign bus.preld_val = lat_preset;
  assign bus._updown   = lat_up;
  assign bus._wrapstop = ~busy;
  assign bus.cnt_en    = (state == RUN);
  assign bus.count     = count_q;

endmodule

// File: doc/ucounter_arb.md
UCOUNTER_ARB -- requirements
Module: ucounter_arb

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state changes occur on the rising edge.
REQ-002 SHALL have port _areset, input, 1, asynchronous active-low reset.
REQ-003 SHALL have ports req0/req1, input, 1 each, requester asks for the shared counter; held high for the whole job.
REQ-004 SHALL have ports preset0/preset1, input, 16 each, requester preload value.
REQ-005 SHALL have ports up0/up1, input, 1 each, requester count direction (1=up, 0=down).
REQ-006 SHALL have ports gnt0/gnt1, output, 1 each, counter owned by that requester.
REQ-007 SHALL have ports done0/done1, output, 1 each, one-cycle pulse when the owner's job reaches terminal count.
REQ-008 SHALL have ports abort0/abort1, output, 1 each, one-cycle pulse when the owner drops req before terminal count.
REQ-009 SHALL have port _load, output, 1, active-low counter load strobe.
REQ-010 SHALL have port preld_val, output, 16, counter preload value.
REQ-011 SHALL have port _updown, output, 1, counter direction (1=up, 0=down).
REQ-012 SHALL have port _wrapstop, output, 1, counter terminal mode (0=stop at terminal).
REQ-013 SHALL have port cnt_en, output, 1, counter clock enable.
REQ-014 SHALL have port overflow, input, 1, counter terminal/overflow flag, sampled synchronously.
REQ-015 SHALL have port dcount, input, 16, counter value, passed through to the count output only.
REQ-016 SHALL have port count, output, 16, registered copy of dcount, valid while either gnt is high.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, RUN, DONE.
REQ-018 IDLE: if any req is high, SHALL select one requester, latch its preset/up into internal registers, assert its gnt, and go to LOAD next cycle.
REQ-019 Arbitration SHALL be round-robin; with a single req, that one wins; with both, the requester not served last wins; last-served pointer resets to 1, so req0 wins first.
REQ-020 LOAD: SHALL drive _load=0 for exactly one cycle, with preld_val/_updown from the latched registers and cnt_en=0; then go to RUN.
REQ-021 RUN: SHALL drive _load=1, cnt_en=1, _wrapstop=0; preld_val/_updown SHALL hold the latched values.
REQ-022 RUN: overflow=1 SHALL cause a transition to DONE with cnt_en=0 from the next cycle.
REQ-023 RUN: owner req=0 with overflow=0 SHALL assert abort for the owner for one cycle, drop gnt, update the pointer, and go to IDLE.
REQ-024 RUN: overflow=1 and owner req=0 in the same cycle SHALL be treated as done, not abort.
REQ-025 DONE: SHALL pulse done for the owner for one cycle, drop gnt, set the pointer to the owner, and return to IDLE.
REQ-026 A requester SHALL NOT be re-granted earlier than the cycle after IDLE is entered, giving a one-cycle minimum idle gap.
REQ-027 gnt0 and gnt1 SHALL be mutually exclusive, as SHALL any done/abort pair.
REQ-028 Changes on preset or up after grant SHALL NOT affect the running job.
REQ-029 overflow seen in IDLE or LOAD SHALL be ignored.
REQ-030 count SHALL update every cycle from dcount while either gnt is high, and hold otherwise.

Reset
REQ-031 _areset=0 SHALL immediately force: IDLE, gnt/done/abort=0, _load=1, preld_val=0, _updown=1, _wrapstop=1, cnt_en=0, count=0, pointer=1.
REQ-032 Reset asserted mid-job SHALL discard the job with no done or abort pulse; after release, the FSM SHALL re-arbitrate from IDLE.

Verification
REQ-033 Single requester: req0=1, preset0=16'hFFFD, up0=1, with the counter model -> gnt0 next cycle; _load=0 one cycle with preld_val=FFFD; overflow after 3 RUN cycles; done0 pulse; gnt0=0.
REQ-034 Contention: req0 and req1 both high from reset -> req0 served first, then req1 (preset1=16'h0002, up1=0, terminal after 2 down counts) -> done0 then done1, never overlapping.
REQ-035 Abort: req1 job preset 16'h0000 up, req1 dropped in the 5th RUN cycle -> abort1 one cycle, no done1, gnt1=0, cnt_en=0.
REQ-036 Simultaneous: overflow=1 in the same cycle req0 falls -> done0=1 and abort0=0.
REQ-037 Reset mid-RUN: _areset pulsed low during RUN -> all outputs at reset values immediately, no pulses; after release with req1 high, gnt1 is granted.
REQ-038 Preset stability: preset0 changed during RUN -> preld_val unchanged until the next grant.
